// File: rtl/window_fetcher_v_2x1_fp16_if.sv
// Pixel-in / 2x1-window-out bundle for the vertical FP16 window fetcher.
// Master drives the raster pixel stream; slave returns window, coordinates and valid.
interface window_fetcher_v_2x1_fp16_if #(
  parameter int FP_WIDTH_REG  = 16,
  parameter int WINDOW_HEIGHT = 2,
  parameter int WINDOW_WIDTH  = 1
);
  logic [FP_WIDTH_REG-1:0] data_i;
  logic                    sof_i;
  logic                    valid_i;
  logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o;
  logic [15:0]             col_o;
  logic [15:0]             row_o;
  logic                    valid_o;

  modport master (
    output data_i, sof_i, valid_i,
    input  window_o, col_o, row_o, valid_o
  );

  modport slave (
    input  data_i, sof_i, valid_i,
    output window_o, col_o, row_o, valid_o
  );
endinterface

// File: rtl/window_fetcher_v_2x1_fp16.sv
// Vertical 2x1 FP16 window fetcher: one-line buffer, raster counters, 1-cycle latency.
// Optional WINDOW_FETCHER_V_REPLICATE_BORDER_EN: emit row 0 with the top edge replicated.
module window_fetcher_v_2x1_fp16 #(
  parameter int EXP_WIDTH    = 5,
  parameter int FRAC_WIDTH   = 10,
  parameter int FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input logic clk_i,
  input logic rst_i,
  window_fetcher_v_2x1_fp16_if.slave bus
);
  localparam int AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [15:0] LAST_COL = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMAGE_HEIGHT - 1);

  logic [15:0]             r_col;
  logic [15:0]             r_row;
  logic [FP_WIDTH_REG-1:0] r_mem [IMAGE_WIDTH];
  logic [FP_WIDTH_REG-1:0] r_upper;
  logic [FP_WIDTH_REG-1:0] r_cur;
  logic [15:0]             r_col_o;
  logic [15:0]             r_row_o;
  logic                    r_valid_o;

  logic                    w_take;
  logic                    w_sof;
  logic [15:0]             w_col;
  logic [15:0]             w_row;
  logic [15:0]             w_col_nxt;
  logic [15:0]             w_row_nxt;
  logic [AW-1:0]           w_addr;
  logic [FP_WIDTH_REG-1:0] w_upper;
  logic                    w_emit;

  assign w_take = bus.valid_i;
  assign w_sof  = bus.valid_i & bus.sof_i;

  // sof forces this pixel to (0,0) whatever the counters say
  always_comb begin
    w_col = r_col;
    w_row = r_row;
    if (w_sof) begin
      w_col = '0;
      w_row = '0;
    end
  end

  assign w_addr = w_col[AW-1:0];

  always_comb begin
    w_col_nxt = w_col + 16'd1;
    w_row_nxt = w_row;
    if (w_col == LAST_COL) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == LAST_ROW) ? 16'd0 : w_row + 16'd1;
    end
  end

`ifdef WINDOW_FETCHER_V_REPLICATE_BORDER_EN
  always_comb begin
    w_emit  = 1'b1;
    w_upper = r_mem[w_addr];
    if (w_row == 16'd0) begin
      w_upper = bus.data_i;
    end
  end
`else
  // row 0 has no upper neighbour; the buffer is only filled
  always_comb begin
    w_emit  = (w_row != 16'd0);
    w_upper = r_mem[w_addr];
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_take) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_take) begin
      r_mem[w_addr] <= bus.data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid_o <= 1'b0;
      r_upper   <= '0;
      r_cur     <= '0;
      r_col_o   <= '0;
      r_row_o   <= '0;
    end else begin
      r_valid_o <= w_take & w_emit;
      if (w_take & w_emit) begin
        r_upper <= w_upper;
        r_cur   <= bus.data_i;
        r_col_o <= w_col;
        r_row_o <= w_row;
      end
    end
  end

  assign bus.window_o[0][0] = r_upper;
  assign bus.window_o[1][0] = r_cur;
  assign bus.col_o          = r_col_o;
  assign bus.row_o          = r_row_o;
  assign bus.valid_o        = r_valid_o;
endmodule

// File: tb/tb_window_fetcher_v_2x1_fp16.sv
// Bench for window_fetcher_v_2x1_fp16 on a 4x3 image: vector table,
// directed corner sequences and a random stream against a frame-index model.
module tb_window_fetcher_v_2x1_fp16;
  localparam int W = 4;
  localparam int H = 3;

  typedef struct {
    logic        v;
    logic        s;
    logic [15:0] d;
    logic        ev;
    logic [15:0] up;
    logic [15:0] cur;
    logic [15:0] col;
    logic [15:0] row;
  } vec_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  window_fetcher_v_2x1_fp16_if #(.FP_WIDTH_REG(16)) bus ();

  window_fetcher_v_2x1_fp16 #(
    .EXP_WIDTH   (5),
    .FRAC_WIDTH  (10),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          m_idx;
  logic [15:0] m_line [W];
  logic        g_ev;
  logic [15:0] g_up;
  logic [15:0] g_cur;
  logic [15:0] g_col;
  logic [15:0] g_row;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Position in frame is a linear pixel index; coordinates derive from it.
  task automatic model(input logic v, input logic s, input logic [15:0] d);
    int c;
    int r;
    g_ev = 1'b0;
    if (v) begin
      if (s) m_idx = 0;
      c = m_idx % W;
      r = m_idx / W;
`ifdef WINDOW_FETCHER_V_REPLICATE_BORDER_EN
      g_ev = 1'b1;
      g_up = (r == 0) ? d : m_line[c];
`else
      g_ev = (r != 0);
      g_up = m_line[c];
`endif
      g_cur = d;
      g_col = 16'(c);
      g_row = 16'(r);
      m_line[c] = d;
      m_idx = (m_idx + 1) % (W * H);
    end
  endtask

  task automatic cyc(input logic v, input logic s, input logic [15:0] d);
    model(v, s, d);
    bus.valid_i = v;
    bus.sof_i   = s;
    bus.data_i  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid"}, 32'(bus.valid_o), 32'(g_ev));
    if (g_ev) begin
      chk({tag, " window"}, {bus.window_o[0][0], bus.window_o[1][0]},
          {g_up, g_cur});
      chk({tag, " col"}, 32'(bus.col_o), 32'(g_col));
      chk({tag, " row"}, 32'(bus.row_o), 32'(g_row));
    end
  endtask

  vec_t tbl [W*H];
  int   cnt;
  int   exp_cnt;
  logic seen;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    m_idx  = 0;
    for (int i = 0; i < W; i++) m_line[i] = '0;
    for (int n = 0; n < W*H; n++) begin
      tbl[n].v   = 1'b1;
      tbl[n].s   = (n == 0);
      tbl[n].d   = 16'(16'h3C00 + n);
      tbl[n].cur = 16'(16'h3C00 + n);
      tbl[n].col = 16'(n % W);
      tbl[n].row = 16'(n / W);
`ifdef WINDOW_FETCHER_V_REPLICATE_BORDER_EN
      tbl[n].ev = 1'b1;
      tbl[n].up = (n < W) ? 16'(16'h3C00 + n) : 16'(16'h3C00 + n - W);
`else
      tbl[n].ev = (n >= W);
      tbl[n].up = 16'(16'h3C00 + n - W);
`endif
    end
`ifdef WINDOW_FETCHER_V_REPLICATE_BORDER_EN
    exp_cnt = W * H;
`else
    exp_cnt = W * (H - 1);
`endif

    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.sof_i   = 1'b0;
    bus.data_i  = '0;
    #12;
    chk("reset valid", 32'(bus.valid_o), 32'd0);
    chk("reset window", {bus.window_o[0][0], bus.window_o[1][0]}, 32'd0);
    chk("reset col", 32'(bus.col_o), 32'd0);
    chk("reset row", 32'(bus.row_o), 32'd0);
    rst = 1'b0;

    // steady frame from the vector table
    cnt = 0;
    for (int i = 0; i < W*H; i++) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].d);
      chk("tbl valid", 32'(bus.valid_o), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        cnt++;
        chk("tbl window", {bus.window_o[0][0], bus.window_o[1][0]},
            {tbl[i].up, tbl[i].cur});
        chk("tbl col", 32'(bus.col_o), 32'(tbl[i].col));
        chk("tbl row", 32'(bus.row_o), 32'(tbl[i].row));
      end
    end
    chk("tbl count", cnt, exp_cnt);
    cyc(1'b0, 1'b0, 16'h0);
    check_model("idle");

    // gapped: same outputs, valid_o low after each gap
    cnt = 0;
    for (int i = 0; i < W*H; i++) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].d);
      chk("gap valid", 32'(bus.valid_o), 32'(tbl[i].ev));
      if (bus.valid_o) begin
        cnt++;
        chk("gap window", {bus.window_o[0][0], bus.window_o[1][0]},
            {tbl[i].up, tbl[i].cur});
        chk("gap col", 32'(bus.col_o), 32'(tbl[i].col));
        chk("gap row", 32'(bus.row_o), 32'(tbl[i].row));
      end
      cyc(1'b0, 1'b0, 16'hFFFF);
      chk("gap idle valid", 32'(bus.valid_o), 32'd0);
    end
    chk("gap count", cnt, exp_cnt);

    // two frames back to back, second without sof
    for (int i = 0; i < W*H; i++) begin
      cyc(1'b1, i == 0, 16'(16'h3C00 + i));
      check_model("wrapA");
    end
    for (int i = 0; i < W*H; i++) begin
      cyc(1'b1, 1'b0, 16'(16'h4000 + i));
      check_model("wrapB");
      if (i == W) begin
        chk("wrap first row1", {bus.window_o[0][0], bus.window_o[1][0]},
            {16'h4000, 16'h4004});
        chk("wrap row1 col", 32'({bus.row_o, bus.col_o}), {16'd1, 16'd0});
      end
    end

    // mid-frame sof at pixel 6
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, i == 0, 16'(16'h4800 + i));
      check_model("pre-sof");
    end
    cnt = 0;
    for (int k = 0; k < 2*W; k++) begin
      cyc(1'b1, k == 0, 16'(16'h5000 + k));
      check_model("post-sof");
      if (k < W && bus.valid_o) cnt++;
      if (k == W) begin
        chk("sof resume row", 32'(bus.row_o), 32'd1);
        chk("sof resume col", 32'(bus.col_o), 32'd0);
        chk("sof resume window", {bus.window_o[0][0], bus.window_o[1][0]},
            {16'h5000, 16'h5004});
      end
    end
`ifdef WINDOW_FETCHER_V_REPLICATE_BORDER_EN
    chk("sof row0 outputs", cnt, W);
`else
    chk("sof row0 outputs", cnt, 0);
`endif

    // async reset during row 2
    for (int i = 0; i < 2*W + 2; i++) begin
      cyc(1'b1, i == 0, 16'(16'h5800 + i));
      check_model("pre-rst");
    end
    chk("pre-rst valid high", 32'(bus.valid_o), 32'd1);
    bus.valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async rst valid", 32'(bus.valid_o), 32'd0);
    chk("async rst window", {bus.window_o[0][0], bus.window_o[1][0]}, 32'd0);
    chk("async rst col", 32'(bus.col_o), 32'd0);
    chk("async rst row", 32'(bus.row_o), 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_idx = 0;
    seen  = 1'b0;
    for (int i = 0; i < 2*W; i++) begin
      cyc(1'b1, 1'b0, 16'(16'h6000 + i));
      check_model("post-rst");
      if (i < W && bus.valid_o) seen = 1'b1;
    end
`ifdef WINDOW_FETCHER_V_REPLICATE_BORDER_EN
    chk("post-rst row0 emitted", 32'(seen), 32'd1);
`else
    chk("post-rst row0 silent", 32'(seen), 32'd0);
`endif

    // random stream with special FP16 patterns mixed in
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic        s;
      logic [15:0] d;
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 40) == 0);
      case ($urandom_range(0, 5))
        0:       d = 16'h7E00;
        1:       d = 16'h7C00;
        2:       d = 16'h0001;
        default: d = 16'($urandom);
      endcase
      cyc(v, s, d);
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
